// File: rtl/uart_rxfifo_drain_sched_if.sv
// Byte-stream and FIFO read-side signals of the UART RX FIFO drain scheduler.
// The master modport is the scheduler; the slave modport is its environment.
interface uart_rxfifo_drain_sched_if #(
   parameter int unsigned CNT_W = 2
);
   logic             enable;
   logic             fifo_empty;
   logic [7:0]       fifo_data;
   logic             fifo_read_n;
   logic [7:0]       tx_data;
   logic             tx_valid;
   logic             tx_ready;
   logic             busy;
   logic [CNT_W-1:0] inflight_cnt;
   logic             ovf_err;

   modport master (
      input  enable, fifo_empty, fifo_data, tx_ready,
      output fifo_read_n, tx_data, tx_valid, busy, inflight_cnt, ovf_err
   );

   modport slave (
      output enable, fifo_empty, fifo_data, tx_ready,
      input  fifo_read_n, tx_data, tx_valid, busy, inflight_cnt, ovf_err
   );
endinterface

// File: rtl/uart_rxfifo_drain_sched.sv
// Read-side scheduler for the UART 128x8 FIFO: issues read strobes, tracks the
// fixed FIFO read latency in a shift pipe and lands bytes in a skid buffer
// that feeds a valid/ready byte stream.
module uart_rxfifo_drain_sched #(
   parameter int unsigned RD_LATENCY = 2,
   parameter int unsigned BUF_DEPTH  = 3,
   parameter int unsigned CNT_W      = 2
) (
   input logic                         clock,
   input logic                         reset,
   uart_rxfifo_drain_sched_if.master   bus
);

   localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

   if (BUF_DEPTH < 1) begin : g_bad_depth
      $error("BUF_DEPTH must be at least 1");
   end
   if ((RD_LATENCY < 1) || (RD_LATENCY > 4)) begin : g_bad_latency
      $error("RD_LATENCY must be in 1..4");
   end
   if ((2 ** CNT_W) <= BUF_DEPTH) begin : g_bad_cnt_w
      $error("CNT_W too narrow for BUF_DEPTH");
   end

   typedef enum logic [1:0] {StIdle, StRun, StStop} state_t;

   state_t                r_state;
   logic [RD_LATENCY-1:0] r_pipe;
   logic [7:0]            r_buf [BUF_DEPTH];
   logic [PTR_W-1:0]      r_head;
   logic [PTR_W-1:0]      r_tail;
   logic [CNT_W-1:0]      r_occ;
   logic                  r_ovf;

   logic [CNT_W-1:0]      w_inflight;
   logic [CNT_W:0]        w_reserved;
   logic                  w_issue;
   logic                  w_capture;
   logic                  w_full;
   logic                  w_pop;
   logic                  w_push;

   // Count reads issued but not yet captured.
   always_comb begin
      w_inflight = '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
         w_inflight = w_inflight + CNT_W'(r_pipe[i]);
      end
   end

   // Issue only when every buffer slot, including those owed to in-flight
   // reads, is accounted for; tx_ready is deliberately kept out of this path.
   always_comb begin
      w_reserved = {1'b0, r_occ} + {1'b0, w_inflight};
      w_issue    = (r_state == StRun) & bus.enable & ~bus.fifo_empty &
                   (w_reserved < (CNT_W + 1)'(BUF_DEPTH));
      w_capture  = r_pipe[RD_LATENCY-1];
      w_full     = (r_occ == CNT_W'(BUF_DEPTH));
      w_pop      = (r_occ != '0) & bus.tx_ready;
      w_push     = w_capture & (~w_full | w_pop);
   end

   // Sequencer state and in-flight pipe.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= StIdle;
         r_pipe  <= '0;
      end else begin
         r_pipe[0] <= w_issue;
         for (int i = 1; i < RD_LATENCY; i++) begin
            r_pipe[i] <= r_pipe[i-1];
         end
         case (r_state)
            StIdle: begin
               if (bus.enable) r_state <= StRun;
            end
            StRun: begin
               if (!bus.enable) r_state <= (w_inflight == '0) ? StIdle : StStop;
            end
            StStop: begin
               if (w_inflight == '0) r_state <= StIdle;
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   // Circular skid buffer with sticky overflow tripwire.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < BUF_DEPTH; i++) begin
            r_buf[i] <= 8'h00;
         end
         r_head <= '0;
         r_tail <= '0;
         r_occ  <= '0;
         r_ovf  <= 1'b0;
      end else begin
         if (w_push) begin
            r_buf[r_tail] <= bus.fifo_data;
            r_tail        <= (r_tail == PTR_W'(BUF_DEPTH - 1)) ? '0 : r_tail + 1'b1;
         end
         if (w_pop) begin
            r_head <= (r_head == PTR_W'(BUF_DEPTH - 1)) ? '0 : r_head + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_occ <= r_occ + 1'b1;
            2'b01:   r_occ <= r_occ - 1'b1;
            default: r_occ <= r_occ;
         endcase
         if (w_capture & w_full & ~w_pop) r_ovf <= 1'b1;
      end
   end

   assign bus.fifo_read_n  = ~w_issue;
   assign bus.tx_valid     = (r_occ != '0);
   assign bus.tx_data      = r_buf[r_head];
   assign bus.busy         = (r_state != StIdle);
   assign bus.inflight_cnt = w_inflight;
   assign bus.ovf_err      = r_ovf;

endmodule

// File: tb/tb_uart_rxfifo_drain_sched.sv
// Bench for uart_rxfifo_drain_sched: a latency-accurate FIFO environment plus
// a queue-based reference model checked every cycle, and directed scenarios.
module tb_uart_rxfifo_drain_sched;
   localparam int unsigned RD_LATENCY = 2;
   localparam int unsigned BUF_DEPTH  = 3;
   localparam int unsigned CNT_W      = 2;

   logic clock = 1'b0;
   logic reset = 1'b1;

   uart_rxfifo_drain_sched_if #(.CNT_W(CNT_W)) bus ();

   uart_rxfifo_drain_sched #(
      .RD_LATENCY (RD_LATENCY),
      .BUF_DEPTH  (BUF_DEPTH),
      .CNT_W      (CNT_W)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   // FIFO environment: data appears RD_LATENCY edges after the read strobe.
   logic [7:0] mem [1024];
   logic [9:0] wr_idx = '0;
   logic [9:0] rd_idx;
   logic [7:0] fstage [RD_LATENCY];

   assign bus.fifo_empty = (rd_idx == wr_idx);
   assign bus.fifo_data  = fstage[RD_LATENCY-1];

   always @(posedge clock or posedge reset) begin
      if (reset) begin
         rd_idx <= '0;
         for (int i = 0; i < RD_LATENCY; i++) fstage[i] <= 8'h00;
      end else begin
         if (!bus.fifo_read_n && !bus.fifo_empty) begin
            fstage[0] <= mem[rd_idx];
            rd_idx    <= rd_idx + 1'b1;
         end
         for (int i = 1; i < RD_LATENCY; i++) fstage[i] <= fstage[i-1];
      end
   end

   // Reference model state.
   typedef enum int {MIdle, MRun, MStop} mstate_e;
   typedef struct {
      logic [7:0] b;
      int         due;
   } fly_t;

   mstate_e    m_state;
   logic [7:0] m_src [$];
   logic [7:0] m_buf [$];
   fly_t       m_fly [$];
   logic [7:0] got   [$];
   logic [7:0] ref_q [$];
   int         gcyc = 0;
   int         n_strobe;
   int         step_idx;
   int         first_valid;
   int         n_checks = 0;
   int         n_fail   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_state = MIdle;
      m_src.delete();
      m_buf.delete();
      m_fly.delete();
   endtask

   task automatic push_byte(input logic [7:0] b);
      mem[wr_idx] = b;
      wr_idx      = wr_idx + 1'b1;
      m_src.push_back(b);
   endtask

   // One clock: check outputs against the model, then advance the model over
   // the coming edge. Entered and left at a falling edge.
   task automatic step();
      bit   issue;
      bit   pop;
      fly_t f;
      int   nfly;
      #1;
      issue = (m_state == MRun) && bus.enable && (m_src.size() != 0) &&
              ((m_buf.size() + m_fly.size()) < BUF_DEPTH);
      chk("fifo_empty", bus.fifo_empty, m_src.size() == 0);
      chk("fifo_read_n", bus.fifo_read_n, !issue);
      chk("tx_valid", bus.tx_valid, m_buf.size() != 0);
      if (m_buf.size() != 0) chk("tx_data", bus.tx_data, m_buf[0]);
      chk("inflight_cnt", bus.inflight_cnt, m_fly.size());
      chk("busy", bus.busy, m_state != MIdle);
      chk("ovf_err", bus.ovf_err, 0);
      if (!bus.fifo_read_n) n_strobe++;
      if (bus.tx_valid && first_valid < 0) first_valid = step_idx;
      if (bus.tx_valid && bus.tx_ready) got.push_back(bus.tx_data);
      pop  = (m_buf.size() != 0) && bus.tx_ready;
      nfly = m_fly.size();
      case (m_state)
         MIdle:   if (bus.enable) m_state = MRun;
         MRun:    if (!bus.enable) m_state = (nfly == 0) ? MIdle : MStop;
         default: if (nfly == 0) m_state = MIdle;
      endcase
      if (pop) void'(m_buf.pop_front());
      while (m_fly.size() != 0 && m_fly[0].due == gcyc) begin
         f = m_fly.pop_front();
         if (m_buf.size() < BUF_DEPTH) m_buf.push_back(f.b);
      end
      if (issue) begin
         f.b   = m_src.pop_front();
         f.due = gcyc + RD_LATENCY;
         m_fly.push_back(f);
      end
      gcyc++;
      step_idx++;
      @(negedge clock);
   endtask

   task automatic drain();
      int k = 0;
      bus.enable   = 1'b0;
      bus.tx_ready = 1'b1;
      while ((bus.busy || bus.tx_valid) && k < 50) begin
         step();
         k++;
      end
      chk("drain_done", {bus.busy, bus.tx_valid}, 0);
   endtask

   task automatic start_test();
      got.delete();
      n_strobe    = 0;
      step_idx    = 0;
      first_valid = -1;
   endtask

   initial begin
      int k;
      int pushed;
      logic [7:0] b;

      bus.enable   = 1'b0;
      bus.tx_ready = 1'b0;
      model_reset();
      #2;
      chk("rst_read_n", bus.fifo_read_n, 1);
      chk("rst_valid", bus.tx_valid, 0);
      chk("rst_data", bus.tx_data, 8'h00);
      chk("rst_busy", bus.busy, 0);
      chk("rst_inflight", bus.inflight_cnt, 0);
      chk("rst_ovf", bus.ovf_err, 0);
      @(negedge clock);
      reset = 1'b0;

      // Burst of five bytes with the consumer always ready.
      start_test();
      for (int i = 0; i < 5; i++) push_byte(8'h10 + 8'(i));
      bus.tx_ready = 1'b1;
      bus.enable   = 1'b1;
      repeat (12) step();
      chk("burst_strobes", n_strobe, 5);
      chk("burst_first_valid", first_valid, RD_LATENCY + 2);
      chk("burst_count", got.size(), 5);
      for (int i = 0; i < 5 && i < got.size(); i++) chk("burst_byte", got[i], 8'h10 + 8'(i));
      drain();

      // Backpressure: only BUF_DEPTH reads may be outstanding.
      start_test();
      for (int i = 0; i < 6; i++) push_byte(8'h20 + 8'(i));
      bus.tx_ready = 1'b0;
      bus.enable   = 1'b1;
      repeat (10) step();
      #1;
      chk("bp_strobes", n_strobe, BUF_DEPTH);
      chk("bp_valid", bus.tx_valid, 1);
      chk("bp_head", bus.tx_data, 8'h20);
      chk("bp_inflight", bus.inflight_cnt, 0);
      @(negedge clock);
      bus.tx_ready = 1'b1;
      k = 0;
      while (got.size() < 6 && k < 40) begin
         step();
         k++;
      end
      chk("bp_count", got.size(), 6);
      for (int i = 0; i < 6 && i < got.size(); i++) chk("bp_byte", got[i], 8'h20 + 8'(i));
      drain();

      // Empty FIFO: no strobes until a byte arrives.
      start_test();
      bus.tx_ready = 1'b1;
      bus.enable   = 1'b1;
      repeat (20) step();
      chk("empty_strobes", n_strobe, 0);
      push_byte(8'hA5);
      repeat (12) step();
      chk("empty_one_strobe", n_strobe, 1);
      chk("empty_count", got.size(), 1);
      if (got.size() > 0) chk("empty_byte", got[0], 8'hA5);
      drain();

      // Disable right after the second issue.
      start_test();
      for (int i = 0; i < 4; i++) push_byte(8'h31 + 8'(i));
      bus.tx_ready = 1'b1;
      bus.enable   = 1'b1;
      repeat (3) step();
      bus.enable = 1'b0;
      k = 0;
      while ((bus.busy || bus.tx_valid) && k < 20) begin
         step();
         k++;
      end
      chk("dis_idle", bus.busy, 0);
      chk("dis_strobes", n_strobe, 2);
      chk("dis_count", got.size(), 2);
      for (int i = 0; i < 2 && i < got.size(); i++) chk("dis_byte", got[i], 8'h31 + 8'(i));
      chk("dis_fifo_left", 32'(wr_idx - rd_idx), 2);

      // Asynchronous reset with two reads in flight.
      reset = 1'b1;
      wr_idx = '0;
      @(negedge clock);
      reset = 1'b0;
      model_reset();
      start_test();
      for (int i = 0; i < 6; i++) push_byte(8'h40 + 8'(i));
      bus.tx_ready = 1'b0;
      bus.enable   = 1'b1;
      repeat (4) step();
      #1;
      chk("pre_rst_inflight", bus.inflight_cnt, 2);
      chk("pre_rst_valid", bus.tx_valid, 1);
      #1;
      reset  = 1'b1;
      wr_idx = '0;
      #1;
      chk("arst_valid", bus.tx_valid, 0);
      chk("arst_read_n", bus.fifo_read_n, 1);
      chk("arst_inflight", bus.inflight_cnt, 0);
      chk("arst_busy", bus.busy, 0);
      chk("arst_data", bus.tx_data, 8'h00);
      @(negedge clock);
      bus.enable = 1'b0;
      reset      = 1'b0;
      model_reset();

      // Random stream with random backpressure.
      start_test();
      ref_q.delete();
      pushed     = 0;
      bus.enable = 1'b1;
      k          = 0;
      while ((pushed < 200 || got.size() < 200) && k < 4000) begin
         if (pushed < 200 && $urandom_range(0, 3) != 0) begin
            b = 8'($urandom);
            push_byte(b);
            ref_q.push_back(b);
            pushed++;
         end
         bus.tx_ready = ($urandom_range(0, 3) != 0);
         step();
         k++;
      end
      chk("rand_count", got.size(), 200);
      for (int i = 0; i < 200 && i < got.size(); i++) chk("rand_byte", got[i], ref_q[i]);
      drain();
      chk("final_ovf", bus.ovf_err, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
